cover_toggle_drain: RTL
=======================

# cover_toggle_drain

Sticky-hit collector and serializer for toggle-coverage points. Samples a WIDTH-bit vector of toggle-hit strobes each cycle and records the first hit of every point. Drains recorded hits one at a time, as absolute cover indices, over a valid/ready port to the single coverage reporter. This replaces per-bit, per-cycle reporter calls with at most one report per point per clear epoch, at one report per cycle.

## Interface
- WIDTH, 42, number of toggle points handled by this instance
- COVER_INDEX, 0, absolute cover index of point 0; point i reports COVER_INDEX+i
- COVER_TOTAL, 10906, total cover points in the design; COVER_INDEX+WIDTH must be ≤ COVER_TOTAL (elaboration-time check)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- enable  in  1  1 = sample valid; 0 = ignore valid, draining continues
- valid  in  WIDTH  per-point hit strobe, sampled every cycle
- clear  in  1  one-cycle pulse: re-arm all points (new epoch)
- out_valid  out  1  out_index holds a report
- out_ready  in  1  reporter accepts this cycle
- out_index  out  64  absolute cover index being reported
- hit_count  out  $clog2(WIDTH+1)  distinct points issued this epoch
- idle  out  1  no pending points and out_valid=0

## Operation
- Internal state: pending[WIDTH], issued[WIDTH], output register {out_valid, out_index}, hit_count.
- Capture: if enable=1, clear=0, valid[i]=1, issued[i]=0 → pending[i] set at the edge. A point already pending or issued is not re-recorded. A held-high strobe yields one report only.
- Selection: lowest-numbered set bit of pending (fixed priority; each point reports at most once, so starvation cannot occur).
- Load: output register loads when out_valid=0, or when out_valid=1 and out_ready=1 (handshake).
  - On load: the selected point's pending bit clears, its issued bit sets, out_index = COVER_INDEX + sel (64-bit, zero-extended), hit_count increments.
  - No pending bit set → out_valid goes/stays 0.
- Output FSM: EMPTY (out_valid=0) → FULL on load. FULL stays FULL on handshake with pending≠0, or without handshake. FULL → EMPTY on handshake with pending=0.
- Hold rule: while out_valid=1 and out_ready=0, out_index stays stable.
- clear: at the edge, pending, issued and hit_count go to 0. Strobes sampled in the clear cycle are discarded. An in-flight report (out_valid=1) is kept and drained; it does not count toward the new epoch's hit_count. No load occurs on the clear edge.
- Same-cycle strobe on the point currently being loaded: issued wins, no second report.
- idle = (pending==0) & ~out_valid.

## Timing
- Reset (async assert, sync-safe deassert by the caller): out_valid=0, out_index=0, hit_count=0, idle=1, pending=0, issued=0.
- Latency: strobe high in cycle N → pending after edge N → out_valid=1 after edge N+1 if the output was EMPTY. The output is registered; there is no combinational path from valid to out_*.
- Throughput: one report per cycle with out_ready held 1. Full drain of WIDTH points after a simultaneous all-ones strobe takes WIDTH+1 cycles from the strobe.
- out_ready is never combinationally used to drive out_valid.
- Reset asserted mid-drain discards all state immediately; no partial report is emitted after release.

## Structure
- Shared package cover_pkg: COVER_IDX_W=64 and the cover-index typedef, also used by the reporter and the other toggle collectors.
- Sub-module cover_prio_enc: parameterized lowest-set-bit encoder (WIDTH in; index and any-set out), reused by other coverage drains.
- All remaining logic (bitmaps, output FSM, counter) lives in cover_toggle_drain.

## Test plan
- Reset release, COVER_INDEX=100, valid[5] pulsed 1 cycle, out_ready=1 → out_valid exactly 1 cycle, out_index=105, 2-cycle latency, hit_count=1, idle=1 after.
- valid=all-ones for 10 cycles, out_ready=1 → indices 100..141 in ascending order on consecutive cycles, no repeats, hit_count=42.
- out_ready=0 for 5 cycles with valid[3] and valid[7] hit → out_index=103 held stable; after ready rises, 103 then 107.
- valid[2] hit and reported, clear pulsed, valid[2] hit again → 102 reported twice in total, hit_count=1 in the new epoch.
- clear while out_valid=1 and out_ready=0 with index 110 → 110 still delivered; pending points dropped; hit_count=0.
- enable=0 with valid=all-ones → no reports; reset asserted mid-drain → out_valid=0 asynchronously, nothing emitted after release.

Source files
------------

// File: rtl/cover_pkg.sv
// cover_pkg: shared cover-index width, index type and drain output states.
package cover_pkg;
  localparam int COVER_IDX_W = 64;
  typedef logic [COVER_IDX_W-1:0] cover_idx_t;
  typedef enum logic {EMPTY, FULL} drain_state_t;
endpackage

// File: rtl/cover_prio_enc.sv
// cover_prio_enc: lowest-set-bit priority encoder with any-set flag.
module cover_prio_enc #(
  parameter int WIDTH = 42,
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [IW-1:0]    idx,
  output logic             any
);
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) idx = req[i] ? IW'(i) : idx;
    any = |req;
  end
endmodule

// File: rtl/cover_toggle_drain.sv
// cover_toggle_drain: sticky toggle-hit collector draining one absolute cover index per cycle.
module cover_toggle_drain
  import cover_pkg::*;
#(
  parameter int WIDTH       = 42,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 10906,
  localparam int CW = $clog2(WIDTH + 1),
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [WIDTH-1:0]       valid,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COVER_IDX_W-1:0] out_index,
  output logic [CW-1:0]          hit_count,
  output logic                   idle
);
  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_err
    $error("cover_toggle_drain: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
  end
  logic [WIDTH-1:0] pending, issued, cap, grant;
  logic [IW-1:0] sel;
  logic any, load;
  drain_state_t state;
  cover_prio_enc #(.WIDTH(WIDTH)) u_enc (.req(pending), .idx(sel), .any(any));
  assign load = ~clear & (state == EMPTY | out_ready);
  assign cap = (enable & ~clear) ? valid & ~issued : '0;
  // a strobe on the point being loaded is masked by the grant, so it never re-arms
  assign grant = (load & any) ? WIDTH'(1) << sel : '0;
  assign out_valid = state == FULL;
  assign idle = ~|pending & ~out_valid;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      out_index <= '0;
      hit_count <= '0;
      pending   <= '0;
      issued    <= '0;
    end else if (clear) begin
      pending   <= '0;
      issued    <= '0;
      hit_count <= '0;
      if (out_ready) state <= EMPTY;
    end else begin
      pending <= (pending | cap) & ~grant;
      issued  <= issued | grant;
      if (load) state <= any ? FULL : EMPTY;
      if (load & any) begin
        out_index <= cover_idx_t'(COVER_INDEX) + cover_idx_t'(sel);
        hit_count <= hit_count + CW'(1);
      end
    end
  end
endmodule
